// File: rtl/memory_access_pkg.sv
// memory_access_pkg: shared encodings for the memory stage (sizes, causes, wb_ctrl layout, FSM states).
package memory_access_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [3:0] ECAUSE_LOAD_MISALIGNED = 4'd4;
  localparam logic [3:0] ECAUSE_STORE_MISALIGNED = 4'd6;
  typedef struct packed {
    logic [1:0]  write_select;
    logic [4:0]  rd_address;
    logic [11:0] csr_address;
    logic        csr_write;
    logic        mret;
    logic        wfi;
  } wb_ctrl_t;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;
  // size 3 falls through to the word rule
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return (size == SIZE_BYTE) ? 1'b0 : (size == SIZE_HALF) ? lo[0] : (lo != 2'b00);
  endfunction
endpackage

// File: rtl/memory_access_if.sv
// memory_access_if: single-outstanding req/ack data bus between the memory stage and memory.
interface memory_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, input mem_ack, mem_rdata);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, output mem_ack, mem_rdata);
endinterface

// File: rtl/memory_access_load_store_align.sv
// memory_access_load_store_align: store strobes/lane replication and load lane extraction/extension.
module memory_access_load_store_align
  import memory_access_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  always_comb begin
    lane_byte   = 8'(rdata_i >> {addr_lo_i, 3'b000});
    lane_half   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    wstrb_o     = (size_i == SIZE_BYTE) ? 4'b0001 << addr_lo_i :
                  (size_i == SIZE_HALF) ? 4'b0011 << addr_lo_i : 4'b1111;
    wdata_o     = (size_i == SIZE_BYTE) ? {4{store_data_i[7:0]}} :
                  (size_i == SIZE_HALF) ? {2{store_data_i[15:0]}} : store_data_i;
    load_data_o = (size_i == SIZE_BYTE) ? {{24{signed_i & lane_byte[7]}}, lane_byte} :
                  (size_i == SIZE_HALF) ? {{16{signed_i & lane_half[15]}}, lane_half} : rdata_i;
  end
endmodule

// File: rtl/memory_access.sv
// memory_access: RV32 memory stage; runs one bus access per load/store and registers results for writeback.
module memory_access
  import memory_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_in,
  input  logic [31:0] next_pc_in,
  input  logic [31:0] alu_data_in,
  input  logic [31:0] rs2_data_in,
  input  logic [31:0] csr_data_in,
  input  logic        load_in,
  input  logic        store_in,
  input  logic [1:0]  load_store_size_in,
  input  logic        load_signed_in,
  input  logic [21:0] wb_ctrl_in,
  input  logic        valid_in,
  input  logic        exception_in,
  input  logic [3:0]  ecause_in,
  input  logic        stall,
  input  logic        invalidate,
  output logic        busy,
  memory_access_if.master bus,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] alu_data_out,
  output logic [31:0] csr_data_out,
  output logic [31:0] load_data_out,
  output logic [21:0] wb_ctrl_out,
  output logic        valid_out,
  output logic        exception_out,
  output logic [3:0]  ecause_out
);
  state_e      state_q, state_d;
  logic        kill_q, kill_d;
  logic        is_access, misaligned, needs_access, start, ack, capture;
  logic [3:0]  lsa_wstrb;
  logic [31:0] lsa_wdata, lsa_load;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q, load_q;
  logic [3:0]  mem_wstrb_q;
  logic [31:0] pc_q, next_pc_q, alu_q, csr_q, load_out_q;
  wb_ctrl_t    wb_ctrl_q;
  logic        valid_q, exception_q;
  logic [3:0]  ecause_q;

  assign is_access    = load_in | store_in;
  assign misaligned   = is_access & is_misaligned(load_store_size_in, alu_data_in[1:0]);
  assign needs_access = valid_in & ~invalidate & ~exception_in & is_access & ~misaligned;

  memory_access_load_store_align u_align (
    .size_i      (load_store_size_in),
    .signed_i    (load_signed_in),
    .addr_lo_i   (alu_data_in[1:0]),
    .store_data_i(rs2_data_in),
    .rdata_i     (bus.mem_rdata),
    .wstrb_o     (lsa_wstrb),
    .wdata_o     (lsa_wdata),
    .load_data_o (lsa_load)
  );

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= ST_IDLE;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end

  // a killed access still waits for its ack, then drops back to IDLE without capturing
  always_comb begin
    kill_d  = kill_q | ((state_q == ST_ACCESS) & invalidate);
    state_d = state_q;
    if (state_q == ST_IDLE && needs_access) state_d = ST_ACCESS;
    else if (state_q == ST_ACCESS && bus.mem_ack) begin
      state_d = kill_d ? ST_IDLE : ST_DONE;
      kill_d  = 1'b0;
    end else if (state_q == ST_DONE && !stall) state_d = ST_IDLE;
  end

  always_comb begin
    start   = (state_q == ST_IDLE) & needs_access;
    ack     = (state_q == ST_ACCESS) & bus.mem_ack;
    busy    = start | (state_q == ST_ACCESS);
    capture = ~stall & valid_in & ~invalidate & ~busy & (~needs_access | (state_q == ST_DONE));
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      load_q      <= '0;
    end else if (start) begin
      mem_req_q   <= 1'b1;
      mem_we_q    <= store_in;
      mem_addr_q  <= {alu_data_in[31:2], 2'b00};
      mem_wdata_q <= lsa_wdata;
      mem_wstrb_q <= store_in ? lsa_wstrb : 4'b0000;
    end else if (ack) begin
      mem_req_q <= 1'b0;
      load_q    <= lsa_load;
    end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pc_q        <= '0;
      next_pc_q   <= '0;
      alu_q       <= '0;
      csr_q       <= '0;
      load_out_q  <= '0;
      wb_ctrl_q   <= '0;
      valid_q     <= 1'b0;
      exception_q <= 1'b0;
      ecause_q    <= '0;
    end else if (!stall) begin
      valid_q <= capture;
      if (capture) begin
        pc_q        <= pc_in;
        next_pc_q   <= next_pc_in;
        alu_q       <= alu_data_in;
        csr_q       <= csr_data_in;
        load_out_q  <= (needs_access & load_in) ? load_q : 32'd0;
        wb_ctrl_q   <= wb_ctrl_t'(wb_ctrl_in);
        exception_q <= exception_in | misaligned;
        ecause_q    <= exception_in ? ecause_in :
                       misaligned ? (load_in ? ECAUSE_LOAD_MISALIGNED : ECAUSE_STORE_MISALIGNED) : 4'd0;
      end
    end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign pc_out        = pc_q;
  assign next_pc_out   = next_pc_q;
  assign alu_data_out  = alu_q;
  assign csr_data_out  = csr_q;
  assign load_data_out = load_out_q;
  assign wb_ctrl_out   = wb_ctrl_q;
  assign valid_out     = valid_q;
  assign exception_out = exception_q;
  assign ecause_out    = ecause_q;
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed vectors with a writeback scoreboard and a bus-request scoreboard.
module tb_memory_access;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in, next_pc_in, alu_data_in, rs2_data_in, csr_data_in;
  logic        load_in, store_in, load_signed_in, valid_in, exception_in, stall, invalidate;
  logic [1:0]  load_store_size_in;
  logic [21:0] wb_ctrl_in;
  logic [3:0]  ecause_in;
  logic        busy;
  logic [31:0] pc_out, next_pc_out, alu_data_out, csr_data_out, load_data_out;
  logic [21:0] wb_ctrl_out;
  logic        valid_out, exception_out;
  logic [3:0]  ecause_out;

  int          total = 0;
  int          bad = 0;
  int          wait_cycles = 0;
  logic [31:0] rdata_cfg = '0;
  logic        ack_auto = 1'b0;
  logic        ack_force = 1'b0;
  logic [31:0] pc_ctr = 32'h1000;

  typedef struct {
    logic [31:0] pc, npc, alu, csr, ld;
    logic [21:0] wb;
    logic        exc;
    logic [3:0]  ec;
  } wb_t;
  typedef struct {
    logic [31:0] addr, wdata;
    logic        we;
    logic [3:0]  wstrb;
  } req_t;
  wb_t  exp_q[$];
  req_t req_q[$];

  memory_access_if bus();
  assign bus.mem_ack   = ack_auto | ack_force;
  assign bus.mem_rdata = rdata_cfg;

  memory_access dut (
    .clk(clk), .reset_n(rst_n),
    .pc_in(pc_in), .next_pc_in(next_pc_in), .alu_data_in(alu_data_in),
    .rs2_data_in(rs2_data_in), .csr_data_in(csr_data_in),
    .load_in(load_in), .store_in(store_in), .load_store_size_in(load_store_size_in),
    .load_signed_in(load_signed_in), .wb_ctrl_in(wb_ctrl_in),
    .valid_in(valid_in), .exception_in(exception_in), .ecause_in(ecause_in),
    .stall(stall), .invalidate(invalidate), .busy(busy), .bus(bus),
    .pc_out(pc_out), .next_pc_out(next_pc_out), .alu_data_out(alu_data_out),
    .csr_data_out(csr_data_out), .load_data_out(load_data_out), .wb_ctrl_out(wb_ctrl_out),
    .valid_out(valid_out), .exception_out(exception_out), .ecause_out(ecause_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory model: acks after wait_cycles cycles of mem_req
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      ack_auto = 1'b0;
      if (bus.mem_req === 1'b1) begin
        if (cnt >= wait_cycles) begin
          ack_auto = 1'b1;
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && valid_out === 1'b1) begin
        if (exp_q.size() == 0) check("spurious_valid", valid_out, 1'b0);
        else begin
          wb_t e;
          e = exp_q.pop_front();
          check("passthru", {pc_out, next_pc_out, alu_data_out, csr_data_out, wb_ctrl_out},
                {e.pc, e.npc, e.alu, e.csr, e.wb});
          check("load_data", load_data_out, e.ld);
          check("exception", exception_out, e.exc);
          if (e.exc) check("ecause", ecause_out, e.ec);
        end
      end
    end
  end

  initial begin
    logic prev = 1'b0;
    logic [68:0] held = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1 && !prev) begin
        if (req_q.size() == 0) check("spurious_req", bus.mem_req, 1'b0);
        else begin
          req_t r;
          r = req_q.pop_front();
          check("req_fields", {bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_wstrb},
                {r.addr, r.we, r.wdata, r.wstrb});
        end
        held = {bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_wstrb};
      end else if (bus.mem_req === 1'b1)
        check("req_stable", {bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_wstrb}, held);
      prev = (bus.mem_req === 1'b1);
    end
  end

  task automatic bubble();
    valid_in = 0; load_in = 0; store_in = 0; exception_in = 0; invalidate = 0;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] rs2, input logic exc,
                       input logic [3:0] ec, input logic [31:0] exp_ld, input logic exp_exc,
                       input logic [3:0] exp_ec);
    wb_t e;
    pc_ctr = pc_ctr + 32'h10;
    pc_in = pc_ctr; next_pc_in = pc_ctr + 4; alu_data_in = addr; rs2_data_in = rs2;
    csr_data_in = ~addr; wb_ctrl_in = 22'(pc_ctr * 7 + 22'h15A5A);
    load_in = ld; store_in = st; load_store_size_in = sz; load_signed_in = sg;
    exception_in = exc; ecause_in = ec; valid_in = 1; invalidate = 0;
    e = '{pc: pc_in, npc: next_pc_in, alu: addr, csr: ~addr, ld: exp_ld, wb: wb_ctrl_in,
          exc: exp_exc, ec: exp_ec};
    exp_q.push_back(e);
  endtask

  // holds the instruction until the stage consumes it, then checks valid_out and bubbles
  task automatic issue(input string name, input int exp_busy);
    int  n = 0;
    logic done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (!busy && !stall) begin
        done = 1'b1;
        break;
      end
      n++;
      @(negedge clk);
    end
    if (!done) check({name, "_timeout"}, 1'b0, 1'b1);
    check({name, "_busy_cycles"}, n, exp_busy);
    @(negedge clk);
    check({name, "_valid"}, valid_out, 1'b1);
    bubble();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; stall = 0; bubble();
    pc_in = 0; next_pc_in = 0; alu_data_in = 0; rs2_data_in = 0; csr_data_in = 0;
    load_store_size_in = 0; load_signed_in = 0; wb_ctrl_in = 0; ecause_in = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_outputs", {valid_out, exception_out, ecause_out, pc_out, alu_data_out, load_data_out},
          '0);
    check("rst_bus", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wstrb}, '0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // non-memory instruction
    drive(0, 0, 2'd2, 0, 32'h1234, 32'h0, 0, 0, 32'h0, 0, 0);
    issue("nonmem", 0);
    @(negedge clk);
    check("nonmem_one_shot", valid_out, 1'b0);

    // signed byte load at 0x103, two wait cycles
    wait_cycles = 2; rdata_cfg = 32'h80FF_FFFF;
    req_q.push_back('{addr: 32'h100, wdata: 32'h0, we: 0, wstrb: 4'b0000});
    drive(1, 0, 2'd0, 1, 32'h103, 32'h0, 0, 0, 32'hFFFF_FF80, 0, 0);
    issue("lb", 4);
    @(negedge clk);

    // unsigned half load, upper half, zero wait
    wait_cycles = 0; rdata_cfg = 32'h8765_4321;
    req_q.push_back('{addr: 32'h100, wdata: 32'h0, we: 0, wstrb: 4'b0000});
    drive(1, 0, 2'd1, 0, 32'h102, 32'h0, 0, 0, 32'h0000_8765, 0, 0);
    issue("lhu", 2);

    // signed half load, lower half, one wait
    wait_cycles = 1; rdata_cfg = 32'h1234_F00D;
    req_q.push_back('{addr: 32'h200, wdata: 32'h0, we: 0, wstrb: 4'b0000});
    drive(1, 0, 2'd1, 1, 32'h200, 32'h0, 0, 0, 32'hFFFF_F00D, 0, 0);
    issue("lh", 3);

    // word load via size code 3
    wait_cycles = 0; rdata_cfg = 32'hDEAD_BEEF;
    req_q.push_back('{addr: 32'h300, wdata: 32'h0, we: 0, wstrb: 4'b0000});
    drive(1, 0, 2'd3, 0, 32'h300, 32'h0, 0, 0, 32'hDEAD_BEEF, 0, 0);
    issue("lw", 2);

    // half store at 0x202
    req_q.push_back('{addr: 32'h200, wdata: 32'hABCD_ABCD, we: 1, wstrb: 4'b1100});
    drive(0, 1, 2'd1, 0, 32'h202, 32'h0000_ABCD, 0, 0, 32'h0, 0, 0);
    issue("sh", 2);

    // byte store at 0x101
    req_q.push_back('{addr: 32'h100, wdata: 32'h7878_7878, we: 1, wstrb: 4'b0010});
    drive(0, 1, 2'd0, 0, 32'h101, 32'h1234_5678, 0, 0, 32'h0, 0, 0);
    issue("sb", 2);

    // misaligned accesses and upstream exception priority
    drive(1, 0, 2'd2, 0, 32'h301, 32'h0, 0, 0, 32'h0, 1, 4'd4);
    issue("lw_mis", 0);
    drive(0, 1, 2'd2, 0, 32'h302, 32'h0, 0, 0, 32'h0, 1, 4'd6);
    issue("sw_mis", 0);
    drive(0, 1, 2'd1, 0, 32'h203, 32'h0, 0, 0, 32'h0, 1, 4'd6);
    issue("sh_mis", 0);
    drive(1, 0, 2'd2, 0, 32'h301, 32'h0, 1, 4'd2, 32'h0, 1, 4'd2);
    issue("exc_in", 0);
    @(negedge clk);

    // invalidate during ACCESS: access completes, nothing is captured
    wait_cycles = 3; rdata_cfg = 32'h5555_AAAA;
    req_q.push_back('{addr: 32'h400, wdata: 32'h0, we: 0, wstrb: 4'b0000});
    drive(1, 0, 2'd1, 0, 32'h400, 32'h0, 0, 0, 32'h0, 0, 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    check("kill_req", bus.mem_req, 1'b1);
    invalidate = 1;
    @(negedge clk);
    bubble();
    repeat (3) @(negedge clk);
    #1;
    check("kill_idle", {bus.mem_req, busy}, 2'b00);
    repeat (2) begin
      @(negedge clk);
      check("kill_no_valid", valid_out, 1'b0);
    end
    wait_cycles = 0;
    drive(0, 0, 2'd0, 0, 32'h44, 32'h0, 0, 0, 32'h0, 0, 0);
    issue("after_kill", 0);
    @(negedge clk);

    // stall held three cycles in DONE
    rdata_cfg = 32'h1122_3344;
    req_q.push_back('{addr: 32'h500, wdata: 32'h0, we: 0, wstrb: 4'b0000});
    drive(1, 0, 2'd2, 0, 32'h500, 32'h0, 0, 0, 32'h1122_3344, 0, 0);
    #1;
    check("stall_start_busy", busy, 1'b1);
    @(negedge clk);
    @(negedge clk);
    stall = 1;
    #1;
    check("stall_done_busy", busy, 1'b0);
    check("stall_hold0", valid_out, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("stall_hold", valid_out, 1'b0);
    end
    @(negedge clk);
    stall = 0;
    check("stall_hold3", valid_out, 1'b0);
    @(negedge clk);
    check("stall_release", valid_out, 1'b1);
    bubble();
    @(negedge clk);
    check("stall_once", valid_out, 1'b0);

    // reset in the middle of an access, then a late ack
    wait_cycles = 1000;
    req_q.push_back('{addr: 32'h600, wdata: 32'h0, we: 0, wstrb: 4'b0000});
    drive(1, 0, 2'd2, 0, 32'h600, 32'h0, 0, 0, 32'h0, 0, 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    check("rst_mid_req", bus.mem_req, 1'b1);
    #2;
    rst_n = 0;
    bubble();
    #1;
    check("rst_mid_bus", {bus.mem_req, bus.mem_addr, bus.mem_wstrb, busy}, '0);
    check("rst_mid_out", {valid_out, pc_out, alu_data_out, wb_ctrl_out, load_data_out}, '0);
    @(negedge clk);
    rst_n = 1;
    wait_cycles = 0;
    @(negedge clk);
    ack_force = 1;
    @(negedge clk);
    ack_force = 0;
    repeat (3) begin
      @(negedge clk);
      check("late_ack", {valid_out, bus.mem_req}, 2'b00);
    end
    drive(0, 0, 2'd0, 0, 32'h77, 32'h0, 0, 0, 32'h0, 0, 0);
    issue("after_rst", 0);
    repeat (2) @(negedge clk);

    check("wb_queue_drained", exp_q.size(), 0);
    check("req_queue_drained", req_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
